// File: rtl/alu_result_fifo.sv
// Show-ahead result queue behind the ALU result mux: stores {Y, S, zero flag},
// valid/ready on both sides, with a wrapping count of delivered results.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [W-1:0]           Y,
  input  logic [1:0]             S,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [W-1:0]           out_data,
  output logic [1:0]             out_op,
  output logic                   out_zero,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             done_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  logic [W-1:0]    dataMem [DEPTH];
  logic [1:0]      opMem   [DEPTH];
  logic [DEPTH-1:0] zeroMem;
  logic [AW-1:0]   rdPtr;
  logic [AW-1:0]   wrPtr;
  logic            full;
  logic            push;
  logic            pop;

  assign full      = (count == FullCount);
  assign in_ready  = ~full & ~reset;
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Storage is deliberately left unreset; the empty-forcing below hides it.
  always_ff @(posedge clock) begin
    if (push) begin
      dataMem[wrPtr] <= Y;
      opMem[wrPtr]   <= S;
      zeroMem[wrPtr] <= (Y == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      done_cnt <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) begin
        rdPtr    <= rdPtr + 1'b1;
        done_cnt <= done_cnt + 8'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    out_data = '0;
    out_op   = '0;
    out_zero = 1'b0;
    if (out_valid) begin
      out_data = dataMem[rdPtr];
      out_op   = opMem[rdPtr];
      out_zero = zeroMem[rdPtr];
    end
  end

endmodule
